// File: rtl/conv_to_montgomery.sv
// Converts an operand into the Montgomery domain, y = a * 2^NBITS mod m, by repeated modular doubling.
// Optional range check on the operands is compiled in with CONV_TO_MONT_RANGE_CHK_EN.
module conv_to_montgomery #(
    parameter int unsigned NBITS = 256
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable_p,
    input  logic [NBITS-1:0] a,
    input  logic [NBITS-1:0] m,
    output logic [NBITS-1:0] y,
    output logic             busy,
    output logic             done_irq_p,
    output logic             err_p
);

    localparam int unsigned CW = $clog2(NBITS + 1);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t           state;
    logic [NBITS-1:0] x;
    logic [NBITS-1:0] m_q;
    logic [CW-1:0]    cnt;

    logic [NBITS:0]   dbl_c;
    logic             ge_c;
    logic [NBITS-1:0] x_nxt_c;
    logic [NBITS-1:0] a_red_c;
    logic             range_bad_c;

    // One modular doubling: the low NBITS bits of 2x - m equal the wide subtract's result when 2x >= m.
    always_comb begin
        dbl_c   = {x, 1'b0};
        ge_c    = (dbl_c >= {1'b0, m_q});
        x_nxt_c = ge_c ? (dbl_c[NBITS-1:0] - m_q) : dbl_c[NBITS-1:0];
        a_red_c = (a >= m) ? (a - m) : a;
    end

`ifdef CONV_TO_MONT_RANGE_CHK_EN
    assign range_bad_c = (m == '0) || ({1'b0, a} >= {m, 1'b0});
`else
    assign range_bad_c = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            x          <= '0;
            m_q        <= '0;
            cnt        <= '0;
            y          <= '0;
            busy       <= 1'b0;
            done_irq_p <= 1'b0;
            err_p      <= 1'b0;
        end else begin
            done_irq_p <= 1'b0;
            err_p      <= 1'b0;
            case (state)
                IDLE: begin
                    if (enable_p) begin
                        if (range_bad_c) begin
                            err_p <= 1'b1;
                        end else begin
                            m_q   <= m;
                            x     <= a_red_c;
                            cnt   <= '0;
                            busy  <= 1'b1;
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    x   <= x_nxt_c;
                    cnt <= cnt + CW'(1);
                    if (cnt == CW'(NBITS - 1)) begin
                        y          <= x_nxt_c;
                        done_irq_p <= 1'b1;
                        busy       <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_conv_to_montgomery.sv
// Directed bench for conv_to_montgomery at NBITS=8; hand-computed expectations of a*256 mod m.
// Range-check cases run when CONV_TO_MONT_RANGE_CHK_EN is defined.
module tb_conv_to_montgomery;

    localparam int unsigned NBITS = 8;
    localparam int NVEC = 12;

    logic             clk;
    logic             rst;
    logic             enable_p;
    logic [NBITS-1:0] a;
    logic [NBITS-1:0] m;
    logic [NBITS-1:0] y;
    logic             busy;
    logic             done_irq_p;
    logic             err_p;

    int n_tests;
    int n_fail;

    typedef struct {
        logic [7:0] m;
        logic [7:0] a;
        logic [7:0] y;
    } vec_t;

    vec_t vecs [NVEC];

    conv_to_montgomery #(.NBITS(NBITS)) dut (
        .clk        (clk),
        .rst        (rst),
        .enable_p   (enable_p),
        .a          (a),
        .m          (m),
        .y          (y),
        .busy       (busy),
        .done_irq_p (done_irq_p),
        .err_p      (err_p)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Called just after a posedge (+#1); the next posedge is the load edge E0.
    task automatic start(input logic [7:0] av, input logic [7:0] mv);
        a        = av;
        m        = mv;
        enable_p = 1'b1;
        @(posedge clk);
        #1;
        enable_p = 1'b0;
        a        = 8'hA5;
        m        = 8'h5A;
    endtask

    // Returns edges since E0 until done is seen, and busy samples before it.
    task automatic wait_done(output int lat, output int bcnt);
        lat  = -1;
        bcnt = busy ? 1 : 0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            if (done_irq_p) begin
                lat = k;
                chk("busy_low_at_done", int'(busy), 0);
                break;
            end
            if (busy) bcnt++;
        end
    endtask

    task automatic count_done(input int ncyc, output int nd);
        nd = 0;
        for (int k = 0; k < ncyc; k++) begin
            @(posedge clk);
            #1;
            if (done_irq_p) nd++;
        end
    endtask

    initial begin
        int lat;
        int bcnt;
        int nd;
        logic [7:0] y_prev;

        n_tests = 0;
        n_fail  = 0;

        vecs[0]  = '{m: 8'd13,  a: 8'd5,   y: 8'd6};
        vecs[1]  = '{m: 8'd13,  a: 8'd0,   y: 8'd0};
        vecs[2]  = '{m: 8'd13,  a: 8'd12,  y: 8'd4};
        vecs[3]  = '{m: 8'd13,  a: 8'd13,  y: 8'd0};
        vecs[4]  = '{m: 8'd255, a: 8'd254, y: 8'd254};
        vecs[5]  = '{m: 8'd13,  a: 8'd7,   y: 8'd11};
        vecs[6]  = '{m: 8'd1,   a: 8'd0,   y: 8'd0};
        vecs[7]  = '{m: 8'd200, a: 8'd199, y: 8'd144};
        vecs[8]  = '{m: 8'd255, a: 8'd0,   y: 8'd0};
        vecs[9]  = '{m: 8'd128, a: 8'd100, y: 8'd0};
        vecs[10] = '{m: 8'd251, a: 8'd250, y: 8'd246};
        vecs[11] = '{m: 8'd3,   a: 8'd5,   y: 8'd2};

        rst      = 1'b1;
        enable_p = 1'b0;
        a        = '0;
        m        = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_y", int'(y), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done_irq_p), 0);
        chk("reset_err", int'(err_p), 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Table-driven single conversions
        for (int i = 0; i < NVEC; i++) begin
            start(vecs[i].a, vecs[i].m);
            chk("busy_after_e0", int'(busy), 1);
            wait_done(lat, bcnt);
            chk($sformatf("latency[%0d]", i), lat, NBITS);
            chk($sformatf("busy_cycles[%0d]", i), bcnt, NBITS);
            chk($sformatf("y[%0d]", i), int'(y), int'(vecs[i].y));
            chk($sformatf("err[%0d]", i), int'(err_p), 0);
            @(posedge clk);
            #1;
            chk($sformatf("done_one_cycle[%0d]", i), int'(done_irq_p), 0);
            chk($sformatf("y_hold[%0d]", i), int'(y), int'(vecs[i].y));
        end

        // Back-to-back: enable_p issued during each done cycle
        start(8'd0, 8'd13);
        wait_done(lat, bcnt);
        chk("b2b0_lat", lat, NBITS);
        chk("b2b0_y", int'(y), 0);
        start(8'd12, 8'd13);
        chk("b2b1_busy_no_gap", int'(busy), 1);
        wait_done(lat, bcnt);
        chk("b2b1_lat", lat, NBITS);
        chk("b2b1_y", int'(y), 4);
        start(8'd13, 8'd13);
        wait_done(lat, bcnt);
        chk("b2b2_lat", lat, NBITS);
        chk("b2b2_y", int'(y), 0);

        // enable_p mid-RUN is ignored and not queued
        @(posedge clk);
        #1;
        start(8'd254, 8'd255);
        repeat (3) @(posedge clk);
        #1;
        a        = 8'd1;
        m        = 8'd13;
        enable_p = 1'b1;
        @(posedge clk);
        #1;
        enable_p = 1'b0;
        wait_done(lat, bcnt);
        chk("midrun_lat", lat + 4, NBITS);
        chk("midrun_y", int'(y), 254);
        count_done(2 * NBITS, nd);
        chk("midrun_no_second_done", nd, 0);
        chk("midrun_busy_idle", int'(busy), 0);

        // Reset during RUN discards the partial result
        start(8'd5, 8'd13);
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("abort_busy", int'(busy), 0);
        chk("abort_y", int'(y), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        count_done(2 * NBITS, nd);
        chk("abort_no_done", nd, 0);
        chk("abort_y_after", int'(y), 0);
        start(8'd7, 8'd13);
        wait_done(lat, bcnt);
        chk("after_abort_lat", lat, NBITS);
        chk("after_abort_y", int'(y), 11);

`ifdef CONV_TO_MONT_RANGE_CHK_EN
        // Range errors: no conversion, err_p pulses for one cycle, y untouched
        @(posedge clk);
        #1;
        y_prev = y;
        start(8'd5, 8'd0);
        chk("rc_m0_err", int'(err_p), 1);
        chk("rc_m0_busy", int'(busy), 0);
        @(posedge clk);
        #1;
        chk("rc_m0_err_pulse", int'(err_p), 0);
        count_done(2 * NBITS, nd);
        chk("rc_m0_no_done", nd, 0);
        chk("rc_m0_y", int'(y), int'(y_prev));
        start(8'd26, 8'd13);
        chk("rc_a2m_err", int'(err_p), 1);
        chk("rc_a2m_busy", int'(busy), 0);
        count_done(2 * NBITS, nd);
        chk("rc_a2m_no_done", nd, 0);
        start(8'd25, 8'd13);
        chk("rc_ok_err", int'(err_p), 0);
        wait_done(lat, bcnt);
        chk("rc_ok_lat", lat, NBITS);
        chk("rc_ok_y", int'(y), 4);
`else
        y_prev = y;
        chk("no_rc_err_const", int'(err_p), 0);
        chk("no_rc_y_hold", int'(y), int'(y_prev));
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
